// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
// Holds the FSM state encoding, default bus widths and the one-hot-to-index helper.
package wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;

    // Supports up to 8 masters; callers zero-extend narrower grant vectors.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = idx | (oh[k] ? 3'(k) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of per-master request lines and the shared Wishbone slave port.
// The arbiter takes the slave view; the masters and the downstream slave take the master view.
interface wb_rr_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADR_W       = WB_ADR_W,
    parameter int DAT_W       = WB_DAT_W
);
    logic [NUM_MASTERS-1:0]       i_m_cyc;
    logic [NUM_MASTERS-1:0]       i_m_stb;
    logic [NUM_MASTERS-1:0]       i_m_we;
    logic [NUM_MASTERS*ADR_W-1:0] i_m_adr;
    logic [NUM_MASTERS*DAT_W-1:0] i_m_dat;
    logic [DAT_W-1:0]             o_m_dat;
    logic [NUM_MASTERS-1:0]       o_m_ack;
    logic [NUM_MASTERS-1:0]       o_grant;
    logic                         o_wb_cyc;
    logic                         o_wb_stb;
    logic                         o_wb_we;
    logic [ADR_W-1:0]             o_wb_adr;
    logic [DAT_W-1:0]             o_wb_dat;
    logic [DAT_W-1:0]             i_wb_dat;
    logic                         i_wb_ack;

    modport slave (
        input  i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_wb_dat, i_wb_ack,
        output o_m_dat, o_m_ack, o_grant, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat
    );

    modport master (
        output i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_wb_dat, i_wb_ack,
        input  o_m_dat, o_m_ack, o_grant, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat
    );

endinterface

// File: rtl/wb_rr_arbiter_chk.sv
// Protocol checker for the arbiter outputs; instantiate alongside the arbiter in simulation.
module wb_rr_arbiter_chk #(
    parameter int N     = 2,
    parameter int ADR_W = 32
) (
    input logic             clk,
    input logic             reset_n,
    input logic [N-1:0]     grant,
    input logic [N-1:0]     m_ack,
    input logic             wb_cyc,
    input logic             wb_stb,
    input logic [ADR_W-1:0] wb_adr
);

    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(grant));

    a_ack_in_grant: assert property (@(posedge clk) disable iff (!reset_n)
        (m_ack & ~grant) == '0);

    a_cyc_needs_grant: assert property (@(posedge clk) disable iff (!reset_n)
        wb_cyc |-> (|grant));

    a_stb_in_cyc: assert property (@(posedge clk) disable iff (!reset_n)
        wb_stb |-> wb_cyc);

    a_bus_known: assert property (@(posedge clk) disable iff (!reset_n)
        !$isunknown({wb_cyc, wb_stb, wb_adr}));

endmodule

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: scans requests starting just after the last
// granted index and returns the first requester as a one-hot vector.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     gnt_o,
    output logic             vld_o
);

    logic [N-1:0]   gnt_s;
    logic           found_s;
    logic [IDX_W:0] sum_s;
    logic [IDX_W:0] pos_s;
    logic           hit_s;

    // Walk last+1 .. last (mod N); the one extra index bit keeps the wrap exact.
    always_comb begin
        gnt_s   = '0;
        found_s = 1'b0;
        sum_s   = '0;
        pos_s   = '0;
        hit_s   = 1'b0;
        for (int i = 1; i <= N; i++) begin
            sum_s   = {1'b0, last_i} + (IDX_W+1)'(i);
            pos_s   = (sum_s >= (IDX_W+1)'(N)) ? (sum_s - (IDX_W+1)'(N)) : sum_s;
            hit_s   = ~found_s & req_i[pos_s[IDX_W-1:0]];
            gnt_s[pos_s[IDX_W-1:0]] = gnt_s[pos_s[IDX_W-1:0]] | hit_s;
            found_s = found_s | hit_s;
        end
    end

    assign gnt_o = gnt_s;
    assign vld_o = found_s;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter granting whole Wishbone tenures on one shared slave port.
// Grant is registered; the granted master's request is muxed onto the bus combinationally.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADR_W       = WB_ADR_W,
    parameter int DAT_W       = WB_DAT_W
) (
    input logic              clk,
    input logic              reset_n,
    wb_rr_arbiter_if.slave   bus
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       last_q,  last_d;

    logic [NUM_MASTERS-1:0] win_s;
    logic                   win_vld_s;
    logic [7:0]             grant_ext_s;
    logic [2:0]             gidx_full_s;
    logic [IDX_W-1:0]       gidx_s;
    logic                   gcyc_s;

    logic                   wb_cyc_s;
    logic                   wb_stb_s;
    logic                   wb_we_s;
    logic [ADR_W-1:0]       wb_adr_s;
    logic [DAT_W-1:0]       wb_dat_s;
    logic [NUM_MASTERS-1:0] m_ack_s;

    rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (bus.i_m_cyc),
        .last_i (last_q),
        .gnt_o  (win_s),
        .vld_o  (win_vld_s)
    );

    // Index and cyc of the current grant holder.
    always_comb begin
        grant_ext_s = 8'(grant_q);
        gidx_full_s = onehot_to_idx(grant_ext_s);
        gidx_s      = gidx_full_s[IDX_W-1:0];
        gcyc_s      = |(bus.i_m_cyc & grant_q);
    end

    // Tenure FSM: grant is only taken from IDLE, so tenures are always separated by an idle cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_vld_s) begin
                    state_d = ARB_GRANT;
                    grant_d = win_s;
                end else begin
                    grant_d = '0;
                end
            end
            ARB_GRANT: begin
                if (!gcyc_s) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    last_d  = gidx_s;
                end else begin
                    grant_d = grant_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // AND-OR mux keyed by the one-hot grant so non-granted inputs (even X) never reach the bus.
    always_comb begin
        wb_cyc_s = 1'b0;
        wb_stb_s = 1'b0;
        wb_we_s  = 1'b0;
        wb_adr_s = '0;
        wb_dat_s = '0;
        m_ack_s  = '0;
        if (state_q == ARB_GRANT) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                wb_adr_s = wb_adr_s | (bus.i_m_adr[k*ADR_W +: ADR_W] & {ADR_W{grant_q[k]}});
                wb_dat_s = wb_dat_s | (bus.i_m_dat[k*DAT_W +: DAT_W] & {DAT_W{grant_q[k]}});
            end
            wb_cyc_s = gcyc_s;
            wb_stb_s = |(bus.i_m_stb & bus.i_m_cyc & grant_q);
            wb_we_s  = |(bus.i_m_we & grant_q);
            m_ack_s  = grant_q & {NUM_MASTERS{bus.i_wb_ack & wb_stb_s}};
        end else begin
            m_ack_s  = '0;
        end
    end

    assign bus.o_wb_cyc = wb_cyc_s;
    assign bus.o_wb_stb = wb_stb_s;
    assign bus.o_wb_we  = wb_we_s;
    assign bus.o_wb_adr = wb_adr_s;
    assign bus.o_wb_dat = wb_dat_s;
    assign bus.o_m_ack  = m_ack_s;
    assign bus.o_m_dat  = bus.i_wb_dat;
    assign bus.o_grant  = grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: directed tenures push expected bus/ack events,
// a negedge monitor pops and compares them as the arbiter presents them.
module tb_wb_rr_arbiter;
    import wb_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [N-1:0]  grant;
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] dat;
    } tenure_t;

    typedef struct {
        logic [N-1:0]  ack;
        logic [DW-1:0] dat;
    } ack_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    tenure_t tq[$];
    ack_t    aq[$];

    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.NUM_MASTERS(N), .ADR_W(AW), .DAT_W(DW)) ifc ();

    wb_rr_arbiter #(.NUM_MASTERS(N), .ADR_W(AW), .DAT_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    wb_rr_arbiter_chk #(.N(N), .ADR_W(AW)) u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .grant   (ifc.o_grant),
        .m_ack   (ifc.o_m_ack),
        .wb_cyc  (ifc.o_wb_cyc),
        .wb_stb  (ifc.o_wb_stb),
        .wb_adr  (ifc.o_wb_adr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_m(input int w, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        ifc.i_m_cyc[w]          = cyc;
        ifc.i_m_stb[w]          = stb;
        ifc.i_m_we[w]           = we;
        ifc.i_m_adr[w*AW +: AW] = adr;
        ifc.i_m_dat[w*DW +: DW] = dat;
    endtask

    task automatic expect_tenure(input logic [N-1:0] g, input logic [AW-1:0] adr,
                                 input logic we, input logic [DW-1:0] dat);
        tenure_t t;
        t.grant = g; t.adr = adr; t.we = we; t.dat = dat;
        tq.push_back(t);
    endtask

    // Serves one granted tenure of master w: each beat is acked, stb dropped between beats.
    task automatic one_tenure(input int w, input int beats, input logic [DW-1:0] rdata,
                              input bit again, input logic [AW-1:0] exp_adr);
        ack_t a;
        logic [N-1:0] g;
        g = '0;
        g[w] = 1'b1;
        @(posedge clk); #1;
        for (int b = 0; b < beats; b++) begin
            ifc.i_wb_ack = 1'b1;
            ifc.i_wb_dat = rdata + DW'(b);
            a.ack = g; a.dat = rdata + DW'(b);
            aq.push_back(a);
            @(negedge clk);
            chk("hold_grant", 64'(ifc.o_grant), 64'(g));
            chk("beat_adr", 64'(ifc.o_wb_adr), 64'(exp_adr));
            @(posedge clk); #1;
            ifc.i_wb_ack = 1'b0;
            ifc.i_wb_dat = '0;
            if (b == beats - 1) begin
                ifc.i_m_cyc[w] = 1'b0;
                ifc.i_m_stb[w] = 1'b0;
            end else begin
                ifc.i_m_stb[w] = 1'b0;
                @(negedge clk);
                chk("stb_gap", 64'({ifc.o_wb_cyc, ifc.o_wb_stb, ifc.o_m_ack}), 64'({1'b1, 1'b0, 2'b00}));
                @(posedge clk); #1;
                ifc.i_m_stb[w] = 1'b1;
            end
        end
        @(posedge clk); #1;
        if (again) begin
            ifc.i_m_cyc[w] = 1'b1;
            ifc.i_m_stb[w] = 1'b1;
        end
        @(negedge clk);
        chk("idle_gap", 64'({ifc.o_wb_cyc, ifc.o_grant}), 64'd0);
    endtask

    // Monitor: a rising o_wb_cyc is a tenure start, a nonzero o_m_ack is a returned beat.
    initial begin
        logic cyc_prev;
        tenure_t t;
        ack_t a;
        cyc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.o_wb_cyc === 1'b1 && cyc_prev !== 1'b1) begin
                if (tq.size() == 0) begin
                    chk("unexpected_tenure", 64'(ifc.o_grant), 64'd0);
                end else begin
                    t = tq.pop_front();
                    chk("tenure_grant", 64'(ifc.o_grant), 64'(t.grant));
                    chk("tenure_adr", 64'(ifc.o_wb_adr), 64'(t.adr));
                    chk("tenure_we", 64'(ifc.o_wb_we), 64'(t.we));
                    chk("tenure_dat", 64'(ifc.o_wb_dat), 64'(t.dat));
                end
            end
            if (ifc.o_m_ack !== '0) begin
                if (aq.size() == 0) begin
                    chk("unexpected_ack", 64'(ifc.o_m_ack), 64'd0);
                end else begin
                    a = aq.pop_front();
                    chk("ack_vec", 64'(ifc.o_m_ack), 64'(a.ack));
                    chk("ack_rdata", 64'(ifc.o_m_dat), 64'(a.dat));
                end
            end
            cyc_prev = ifc.o_wb_cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        ifc.i_m_cyc  = '0;
        ifc.i_m_stb  = '0;
        ifc.i_m_we   = '0;
        ifc.i_m_adr  = '0;
        ifc.i_m_dat  = '0;
        ifc.i_wb_ack = 1'b1;
        ifc.i_wb_dat = 32'h5555;
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_0ABC, 32'h0000_0123);

        // Reset state, with a request and a stray ack present.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(ifc.o_grant), 64'd0);
        chk("rst_bus", 64'({ifc.o_wb_cyc, ifc.o_wb_stb, ifc.o_wb_we}), 64'd0);
        chk("rst_adr", 64'(ifc.o_wb_adr), 64'd0);
        chk("rst_dat", 64'(ifc.o_wb_dat), 64'd0);
        chk("rst_ack", 64'(ifc.o_m_ack), 64'd0);
        @(posedge clk); #1;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_ack_ignored", 64'(ifc.o_m_ack), 64'd0);
        @(posedge clk); #1;
        ifc.i_wb_ack = 1'b0;
        ifc.i_wb_dat = '0;

        // 1: single write from m0, one-cycle grant latency.
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h100, 32'hDEAD);
        expect_tenure(2'b01, 32'h100, 1'b1, 32'hDEAD);
        @(negedge clk);
        chk("grant_latency", 64'({ifc.o_wb_cyc, ifc.o_grant}), 64'd0);
        one_tenure(0, 1, 32'h1234, 1'b0, 32'h100);

        // 2: both request every tenure; last was m0 so m1 leads.
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h11);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h22);
        expect_tenure(2'b10, 32'h20, 1'b0, 32'h22);
        one_tenure(1, 1, 32'hA1, 1'b1, 32'h20);
        expect_tenure(2'b01, 32'h10, 1'b0, 32'h11);
        one_tenure(0, 1, 32'hA2, 1'b1, 32'h10);
        expect_tenure(2'b10, 32'h20, 1'b0, 32'h22);
        one_tenure(1, 1, 32'hA3, 1'b0, 32'h20);
        expect_tenure(2'b01, 32'h10, 1'b0, 32'h11);
        one_tenure(0, 1, 32'hA4, 1'b0, 32'h10);

        // 3: m1 read returning 0xCAFE.
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        expect_tenure(2'b10, 32'h200, 1'b0, 32'h0);
        one_tenure(1, 1, 32'hCAFE, 1'b0, 32'h200);

        // 4: m0 holds three beats while m1 waits, then m1 gets its turn.
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h300, 32'hBEEF);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h400, 32'h44);
        expect_tenure(2'b01, 32'h300, 1'b1, 32'hBEEF);
        one_tenure(0, 3, 32'hB0, 1'b0, 32'h300);
        expect_tenure(2'b10, 32'h400, 1'b0, 32'h44);
        one_tenure(1, 1, 32'hB8, 1'b0, 32'h400);

        // 5: reset mid-tenure clears the bus at once; m0 wins first afterwards.
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h500, 32'h55);
        expect_tenure(2'b10, 32'h500, 1'b1, 32'h55);
        @(posedge clk); #1;
        @(negedge clk); #1;
        reset_n = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h600, 32'h66);
        #1;
        chk("rst_mid_bus", 64'({ifc.o_wb_cyc, ifc.o_wb_stb}), 64'd0);
        chk("rst_mid_grant", 64'(ifc.o_grant), 64'd0);
        chk("rst_mid_adr", 64'(ifc.o_wb_adr), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        expect_tenure(2'b01, 32'h600, 1'b0, 32'h66);
        one_tenure(0, 1, 32'h77, 1'b0, 32'h600);
        expect_tenure(2'b10, 32'h500, 1'b1, 32'h55);
        one_tenure(1, 1, 32'h88, 1'b0, 32'h500);

        // 6: idle m1 drives X on its fields while m0 runs a two-beat write.
        set_m(1, 1'b0, 1'b0, 1'bx, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h700, 32'h77);
        expect_tenure(2'b01, 32'h700, 1'b1, 32'h77);
        one_tenure(0, 2, 32'h99, 1'b0, 32'h700);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("tenure_q_empty", 64'(tq.size()), 64'd0);
        chk("ack_q_empty", 64'(aq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
